// File: rtl/nibble_serial_adder.sv
// Serial adder: adds two W-bit operands one nibble per cycle, holding the
// result with a valid/ready handshake until the consumer pops it.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [3:0]         nib_a, nib_b;
  logic [4:0]         slice;
  logic [3:0]         low3;
  logic               last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  // One 4-bit ripple slice; low3 exposes the carry into bit 3 for overflow.
  always_comb begin
    nib_a = a_q[idx_q*4 +: 4];
    nib_b = b_q[idx_q*4 +: 4];
    slice = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, carry_q};
    low3  = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b0, carry_q};
    last  = (idx_q == IDX_W'(NIBBLES - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*4 +: 4] = slice[3:0];
        carry_d             = slice[4];
        if (last) begin
          cout_d  = slice[4];
          ovf_d   = low3[3] ^ slice[4];
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized bench for nibble_serial_adder against an arithmetic reference.
module tb_nibble_serial_adder;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout, ovf, busy;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} from plain integer addition and sign rule.
  function automatic logic [W+1:0] model(logic [W-1:0] x, logic [W-1:0] y, logic c);
    logic [W:0] full;
    logic       v;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {v, full};
  endfunction

  // Drives one operation and waits for out_valid; leaves the result unpopped.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input bit junk, output int lat, output logic [W-1:0] s,
                        output logic co, output logic ov, output bit timeout,
                        output bit saw_ready);
    int cnt = 0;
    timeout = 0;
    saw_ready = 0;
    while (!in_ready && cnt < 50) begin @(negedge clk); cnt++; end
    if (!in_ready) timeout = 1;
    a = x; b = y; cin = c; in_valid = 1'b1;
    @(negedge clk);
    lat = 0;
    if (in_ready) saw_ready = 1;
    while (!out_valid && lat < 50) begin
      if (junk) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (in_ready) saw_ready = 1;
    end
    if (!out_valid) timeout = 1;
    s = sum; co = cout; ov = ovf;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({out_valid, busy, cout, ovf, sum} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ov=%b busy=%b cout=%b ovf=%b sum=%h, want all 0",
               out_valid, busy, cout, ovf, sum);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va[5] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
    logic [W-1:0] vb[5] = '{16'h4321, 16'h0000, 16'h0001, 16'h0001, 16'h8000};
    logic         vc[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [W+1:0] exp;
    logic [W-1:0] s;
    logic co, ov;
    int lat;
    bit to, sr;
    for (int i = 0; i < 5; i++) begin
      exp = model(va[i], vb[i], vc[i]);
      run_op(va[i], vb[i], vc[i], 1'b0, lat, s, co, ov, to, sr);
      n_checks++;
      if (to || lat != NIBBLES) begin
        n_fail++; $display("FAIL vec%0d_latency: got %0d (timeout=%0d) want %0d", i, lat, to, NIBBLES);
      end
      n_checks++;
      if ({ov, co, s} !== exp) begin
        n_fail++;
        $display("FAIL vec%0d_result: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                 i, ov, co, s, exp[W+1], exp[W], exp[W-1:0]);
      end
      pop();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, s;
    logic c, co, ov;
    logic [W+1:0] exp;
    int lat;
    bit to, sr;
    for (int i = 0; i < 20; i++) begin
      x = W'($urandom); y = W'($urandom); c = 1'($urandom);
      exp = model(x, y, c);
      // out_ready held high throughout: must be ignored until DONE.
      out_ready = 1'b1;
      run_op(x, y, c, 1'b0, lat, s, co, ov, to, sr);
      n_checks++;
      if (to || lat != NIBBLES || {ov, co, s} !== exp) begin
        n_fail++;
        $display("FAIL rand%0d: got lat=%0d ovf=%b cout=%b sum=%h want lat=%0d ovf=%b cout=%b sum=%h",
                 i, lat, ov, co, s, NIBBLES, exp[W+1], exp[W], exp[W-1:0]);
      end
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL rand%0d_pop: got out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] s;
    logic co, ov;
    logic [W+1:0] exp;
    int lat;
    bit to, sr;
    exp = model(16'h7FFF, 16'h0001, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, s, co, ov, to, sr);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ovf, cout, sum} !== exp || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL hold%0d: got ovf=%b cout=%b sum=%h rdy=%b busy=%b ov=%b want %b %b %h 0 1 1",
                 i, ovf, cout, sum, in_ready, busy, out_valid, exp[W+1], exp[W], exp[W-1:0]);
      end
    end
    pop();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_pop: got ov=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] s;
    logic co, ov;
    logic [W+1:0] exp1, exp2;
    int lat;
    bit to, sr;
    exp1 = model(16'h0F0F, 16'h10F1, 1'b1);
    exp2 = model(16'hA5A5, 16'h5A5B, 1'b0);
    run_op(16'h0F0F, 16'h10F1, 1'b1, 1'b1, lat, s, co, ov, to, sr);
    n_checks++;
    if (to || sr || lat != NIBBLES || {ov, co, s} !== exp1) begin
      n_fail++;
      $display("FAIL busy_first: got lat=%0d rdy_seen=%0d ovf=%b cout=%b sum=%h want %0d 0 %b %b %h",
               lat, sr, ov, co, s, NIBBLES, exp1[W+1], exp1[W], exp1[W-1:0]);
    end
    a = 16'hA5A5; b = 16'h5A5B; cin = 1'b0; in_valid = 1'b1;
    pop();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL busy_pop: got rdy=%b ov=%b want 1 0", in_ready, out_valid);
    end
    run_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, lat, s, co, ov, to, sr);
    n_checks++;
    if (to || lat != NIBBLES || {ov, co, s} !== exp2) begin
      n_fail++;
      $display("FAIL busy_second: got lat=%0d ovf=%b cout=%b sum=%h want %0d %b %b %h",
               lat, ov, co, s, NIBBLES, exp2[W+1], exp2[W], exp2[W-1:0]);
    end
    pop();
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({out_valid, busy, cout, ovf, sum} !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset: got ov=%b busy=%b cout=%b ovf=%b sum=%h rdy=%b want zeros, rdy=1",
               out_valid, busy, cout, ovf, sum, in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL midreset_no_valid: got out_valid=1 want 0");
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_vectors();
    test_random();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4: number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands a, b and cin are valid this cycle.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-006 The block SHALL have ports a and b, input, W bits each: unsigned/two's-complement addends.
REQ-007 The block SHALL have port cin, input, 1 bit: carry into nibble 0.
REQ-008 The block SHALL have port out_valid, output, 1 bit: sum, cout and ovf are valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream consumes the result this cycle.
REQ-010 The block SHALL have port sum, output, W bits: a + b + cin modulo 2^W.
REQ-011 The block SHALL have port cout, output, 1 bit: carry out of the MSB.
REQ-012 The block SHALL have port ovf, output, 1 bit: signed overflow, i.e. carry into MSB XOR carry out of MSB.
REQ-013 The block SHALL have port busy, output, 1 bit: high in states RUN and DONE.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 Accept: when in IDLE with in_valid=1, the block SHALL register a, b and cin into an operand register and a carry register, clear nibble index idx to 0, and go to RUN.
REQ-017 In RUN, each cycle the block SHALL compute one 4-bit ripple add of a[idx], b[idx] and the carry register, write the 4-bit result into sum[4*idx+3:4*idx], update the carry register with the slice carry, and increment idx.
REQ-018 In RUN, on the cycle with idx = NIBBLES-1, the block SHALL also capture the carry into bit 3 of that slice for ovf, then go to DONE.
REQ-019 Latency: with the accept at edge k, out_valid SHALL be 1 after edge k+NIBBLES, i.e. exactly NIBBLES RUN cycles.
REQ-020 In DONE, out_valid=1 and sum, cout and ovf SHALL be held stable until out_ready=1; on an edge with out_ready=1 the block SHALL go to IDLE and out_valid=0.
REQ-021 There SHALL be no accept in the same cycle as a result pop; the minimum issue interval is NIBBLES+2 cycles.
REQ-022 in_valid, a, b and cin SHALL be ignored outside IDLE, and changing them during RUN SHALL not affect the result.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 idx SHALL be ceil(log2(NIBBLES)) bits, minimum 1, and SHALL never exceed NIBBLES-1.
REQ-025 sum SHALL not be guaranteed outside DONE, except after reset.

Reset
REQ-026 When rst=1 at an edge, the block SHALL go to IDLE and clear sum, cout, ovf, out_valid, busy, idx, the carry register and the operand registers to 0, regardless of state.
REQ-027 rst SHALL take priority over accept and pop; a reset during RUN or DONE SHALL abort the operation and produce no out_valid for it.
REQ-028 After reset release, in_ready SHALL be 1 in the first cycle.

Verification
REQ-029 Basic: a=0x1234, b=0x4321, cin=0 -> out_valid 4 cycles after accept, sum=0x5555, cout=0, ovf=0.
REQ-030 Full carry ripple: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0; also a=0xFFFF, b=0x0001 -> same.
REQ-031 Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum, cout and ovf unchanged, in_ready=0, busy=1; pop -> IDLE next cycle.
REQ-033 Busy-ignore: in_valid=1 with new operands throughout RUN -> the result matches the first operands only, and the second transfer is accepted only after returning to IDLE.
REQ-034 Reset mid-operation: rst=1 at the 2nd RUN cycle -> next cycle all outputs 0, in_ready=1, and no out_valid appears for the aborted operation.
